// File: rtl/lake_stream_checker.sv
// Receive-side checker for a Lake output stream: compares each valid word against
// an arithmetic sequence and records latency, word count, mismatches and overrun.
//
// state | meaning
// IDLE  | not armed, waiting for start
// ARMED | armed, counting cycles until the first valid word
// CHECK | comparing words against the running expected value
// DONE  | num_words reached; further valid words flag overrun
module lake_stream_checker #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 32,
    parameter int ERR_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic                  flush,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] expected_first,
    input  logic [DATA_WIDTH-1:0] stride,
    input  logic [CNT_WIDTH-1:0]  num_words,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  overrun,
    output logic [CNT_WIDTH-1:0]  words_seen,
    output logic [CNT_WIDTH-1:0]  first_latency,
    output logic [ERR_WIDTH-1:0]  error_count,
    output logic                  mismatch_valid,
    output logic [DATA_WIDTH-1:0] mismatch_data,
    output logic [DATA_WIDTH-1:0] mismatch_expected
);

    typedef enum logic [1:0] {IDLE, ARMED, CHECK, DONE} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] cfg_stride;
    logic [CNT_WIDTH-1:0]  cfg_num;
    logic [DATA_WIDTH-1:0] exp_q;
    logic [CNT_WIDTH-1:0]  lat_cnt;

    // A start in DONE re-arms and may check a word on the same edge, so the
    // compare path selects between live inputs and the stored configuration.
    logic                  restart;
    logic [DATA_WIDTH-1:0] acc_exp;
    logic [DATA_WIDTH-1:0] acc_stride;
    logic [CNT_WIDTH-1:0]  acc_num;
    logic [CNT_WIDTH-1:0]  ws_base;
    logic [CNT_WIDTH-1:0]  ws_next;
    logic [ERR_WIDTH-1:0]  err_base;
    logic [ERR_WIDTH-1:0]  err_next;
    logic [CNT_WIDTH-1:0]  lat_next;
    logic                  is_mis;
    logic                  hit_end;

    always_comb begin
        restart    = (state == DONE) && start;
        acc_exp    = restart ? expected_first : exp_q;
        acc_stride = restart ? stride : cfg_stride;
        acc_num    = restart ? num_words : cfg_num;
        ws_base    = restart ? '0 : words_seen;
        err_base   = restart ? '0 : error_count;
        ws_next    = (ws_base == '1) ? ws_base : ws_base + CNT_WIDTH'(1);
        err_next   = (err_base == '1) ? err_base : err_base + ERR_WIDTH'(1);
        lat_next   = (lat_cnt == '1) ? lat_cnt : lat_cnt + CNT_WIDTH'(1);
        is_mis     = (data_in != acc_exp);
        hit_end    = (acc_num != '0) && (ws_next == acc_num);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            cfg_stride        <= '0;
            cfg_num           <= '0;
            exp_q             <= '0;
            lat_cnt           <= '0;
            overrun           <= 1'b0;
            words_seen        <= '0;
            first_latency     <= '0;
            error_count       <= '0;
            mismatch_valid    <= 1'b0;
            mismatch_data     <= '0;
            mismatch_expected <= '0;
        end else if (flush) begin
            state             <= IDLE;
            cfg_stride        <= '0;
            cfg_num           <= '0;
            exp_q             <= '0;
            lat_cnt           <= '0;
            overrun           <= 1'b0;
            words_seen        <= '0;
            first_latency     <= '0;
            error_count       <= '0;
            mismatch_valid    <= 1'b0;
            mismatch_data     <= '0;
            mismatch_expected <= '0;
        end else if (clk_en) begin
            mismatch_valid <= 1'b0;
            if (((state == IDLE) || (state == DONE)) && start) begin
                state             <= ARMED;
                cfg_stride        <= stride;
                cfg_num           <= num_words;
                exp_q             <= expected_first;
                lat_cnt           <= '0;
                overrun           <= 1'b0;
                words_seen        <= '0;
                first_latency     <= '0;
                error_count       <= '0;
                mismatch_data     <= '0;
                mismatch_expected <= '0;
            end else if ((state == DONE) && valid_in) begin
                overrun <= 1'b1;
            end else if ((state == ARMED) && !valid_in) begin
                lat_cnt <= lat_next;
            end

            // Accepted word: later assignments override the arm clears above.
            if (valid_in && ((state == ARMED) || (state == CHECK) || restart)) begin
                if (state == ARMED)
                    first_latency <= lat_next;
                else if (restart)
                    first_latency <= CNT_WIDTH'(1);
                words_seen <= ws_next;
                exp_q      <= acc_exp + acc_stride;
                state      <= hit_end ? DONE : CHECK;
                if (is_mis) begin
                    error_count       <= err_next;
                    mismatch_valid    <= 1'b1;
                    mismatch_data     <= data_in;
                    mismatch_expected <= acc_exp;
                end
            end
        end
    end

    assign busy = (state == ARMED) || (state == CHECK);
    assign done = (state == DONE);
    assign pass = done && (error_count == '0) && !overrun;

endmodule

// File: tb/tb_lake_stream_checker.sv
// Directed bench for lake_stream_checker with hand-computed expectations.
module tb_lake_stream_checker;

    logic        clk = 1'b0;
    logic        rst_n, clk_en, flush, start, valid_in;
    logic [15:0] expected_first, stride, data_in;
    logic [31:0] num_words;
    logic        busy, done, pass, overrun, mismatch_valid;
    logic [31:0] words_seen, first_latency;
    logic [15:0] error_count, mismatch_data, mismatch_expected;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses;

    always #5 clk = ~clk;

    lake_stream_checker dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .start(start),
        .expected_first(expected_first), .stride(stride), .num_words(num_words),
        .data_in(data_in), .valid_in(valid_in), .busy(busy), .done(done), .pass(pass),
        .overrun(overrun), .words_seen(words_seen), .first_latency(first_latency),
        .error_count(error_count), .mismatch_valid(mismatch_valid),
        .mismatch_data(mismatch_data), .mismatch_expected(mismatch_expected)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [15:0] f, input logic [15:0] s, input logic [31:0] n);
        start = 1'b1; expected_first = f; stride = s; num_words = n;
        step();
        start = 1'b0;
    endtask

    task automatic feed(input logic [15:0] d);
        valid_in = 1'b1; data_in = d;
        step();
        if (mismatch_valid) pulses++;
        valid_in = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; start = 1'b0; valid_in = 1'b0;
        expected_first = '0; stride = '0; num_words = '0; data_in = '0;
        step(); step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_words", words_seen, 0);
        rst_n = 1'b1;
        step();

        // 1: clean 8-word ramp
        arm(16'h0, 16'h1, 32'd8);
        check("t1_armed", busy, 1);
        for (int i = 0; i < 8; i++) feed(16'(i));
        check("t1_done", done, 1);
        check("t1_pass", pass, 1);
        check("t1_words", words_seen, 8);
        check("t1_lat", first_latency, 1);
        check("t1_err", error_count, 0);

        // 2: word 3 corrupted
        arm(16'h0, 16'h1, 32'd8);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            feed((i == 3) ? 16'h0033 : 16'(i));
            if (i == 3) begin
                check("t2_mv", mismatch_valid, 1);
                check("t2_mdata", mismatch_data, 16'h0033);
                check("t2_mexp", mismatch_expected, 16'h0003);
            end
        end
        step(); if (mismatch_valid) pulses++;
        check("t2_pulses", pulses, 1);
        check("t2_err", error_count, 1);
        check("t2_pass", pass, 0);
        check("t2_done", done, 1);

        // 3: wrap past 0xFFFF
        arm(16'hFFFE, 16'h1, 32'd4);
        feed(16'hFFFE); feed(16'hFFFF); feed(16'h0000); feed(16'h0001);
        check("t3_pass", pass, 1);
        check("t3_words", words_seen, 4);

        // 4: latency and clk_en freeze
        arm(16'h0010, 16'h2, 32'd6);
        repeat (5) step();
        feed(16'h0010);
        check("t4_lat", first_latency, 6);
        feed(16'h0012); feed(16'h0014);
        clk_en = 1'b0; valid_in = 1'b1; data_in = 16'hDEAD;
        repeat (3) step();
        valid_in = 1'b0; clk_en = 1'b1;
        check("t4_frz_words", words_seen, 3);
        check("t4_frz_err", error_count, 0);
        check("t4_frz_busy", busy, 1);
        feed(16'h0016); feed(16'h0018); feed(16'h001A);
        check("t4_pass", pass, 1);
        check("t4_words", words_seen, 6);

        // 5: overrun then re-arm
        feed(16'h1234);
        check("t5_ovr", overrun, 1);
        check("t5_pass", pass, 0);
        check("t5_words", words_seen, 6);
        arm(16'h0, 16'h5, 32'd2);
        check("t5_ovr_clr", overrun, 0);
        check("t5_armed", busy, 1);
        feed(16'h0); feed(16'h5);
        check("t5_done2", pass, 1);
        start = 1'b1; expected_first = 16'h7; stride = 16'h1; num_words = 32'd3;
        valid_in = 1'b1; data_in = 16'h7;
        step();
        start = 1'b0; valid_in = 1'b0;
        check("t5_sv_lat", first_latency, 1);
        check("t5_sv_words", words_seen, 1);
        check("t5_sv_busy", busy, 1);
        check("t5_sv_err", error_count, 0);

        // 6: flush beats start, then async reset mid-stream
        feed(16'h8);
        check("t6_words", words_seen, 2);
        flush = 1'b1; start = 1'b1; valid_in = 1'b1; data_in = 16'h9;
        step();
        flush = 1'b0; start = 1'b0; valid_in = 1'b0;
        check("t6_fl_busy", busy, 0);
        check("t6_fl_done", done, 0);
        check("t6_fl_words", words_seen, 0);
        check("t6_fl_lat", first_latency, 0);
        arm(16'h0, 16'h1, 32'd0);
        for (int i = 0; i < 10; i++) feed((i == 2) ? 16'h00AA : 16'(i));
        check("t6_unb_busy", busy, 1);
        check("t6_unb_words", words_seen, 10);
        check("t6_unb_err", error_count, 1);
        check("t6_unb_mexp", mismatch_expected, 16'h0002);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_words", words_seen, 0);
        check("t6_rst_err", error_count, 0);
        check("t6_rst_mdata", mismatch_data, 0);
        check("t6_rst_busy", busy, 0);
        step();
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
